fb_avl_port: RTL

- Responder side of the frame-buffer handshake issued by the image capture control logic. One instance sits per frame buffer.
- Accepts active-low per-beat write/read enables plus write data. Converts them into Avalon-MM commands toward the DDR controller port.
- Returns frame status to the control logic: full, rd_done, ready and read-data-valid.
- Tracks write and read frame positions and the number of outstanding reads.

---
 rtl/fb_avl_port.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fb_avl_port.sv
`default_nettype none
// ============================================================================
// Module  : fb_avl_port
// Brief   : Frame-buffer responder; turns active-low pixel write/read beats
//           into registered Avalon-MM commands and reports frame status.
//           Define FB_DBG_CNT_EN to add the dbg_err_cnt error counter port.
// Revision: 1.0 - initial release
// ============================================================================
module fb_avl_port #(
   parameter int          ADDR_WIDTH      = 25,
   parameter int          DATA_WIDTH      = 32,
   parameter int unsigned BASE_ADDR       = 0,
   parameter int          FRAME_PIXELS    = 307200,
   parameter int          BURST_SIZE      = 8,
   parameter int          MAX_OUTSTANDING = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en_n,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_restart,
   input  logic                  rd_en_n,
   input  logic                  rd_restart,
   output logic                  wr_ready,
   output logic                  rd_ready,
   output logic                  full,
   output logic                  rd_done,
   output logic                  rd_data_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  avl_ready,
   output logic [ADDR_WIDTH-1:0] avl_addr,
   output logic                  avl_burstbegin,
   output logic [3:0]            avl_size,
   output logic                  avl_write_req,
   output logic                  avl_read_req,
   output logic [DATA_WIDTH-1:0] avl_wdata,
   input  logic [DATA_WIDTH-1:0] avl_rdata,
   input  logic                  avl_rdata_valid
`ifdef FB_DBG_CNT_EN
   ,
   output logic [15:0]           dbg_err_cnt
`endif
);

   localparam int                   c_ptr_w     = $clog2(FRAME_PIXELS + 1);
   localparam int                   c_ost_w     = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [c_ptr_w-1:0]   c_frame     = c_ptr_w'(FRAME_PIXELS);
   localparam logic [c_ptr_w-1:0]   c_ptr_one   = 1;
   localparam logic [c_ost_w-1:0]   c_ost_max   = c_ost_w'(MAX_OUTSTANDING);
   localparam logic [c_ost_w-1:0]   c_ost_one   = 1;
   localparam logic [3:0]           c_burst_sz  = 4'(BURST_SIZE);
   localparam logic [3:0]           c_beat_last = 4'(BURST_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] c_base     = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_WR_BURST = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_iss_ptr;
   logic [c_ptr_w-1:0]    r_rd_ret_cnt;
   logic [c_ost_w-1:0]    r_outstanding;
   logic [3:0]            r_beat_cnt;
   logic                  r_full;
   logic                  r_rd_done;
   logic                  r_wr_rst_pend;
   logic                  r_rd_data_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;

   logic [ADDR_WIDTH-1:0] r_avl_addr;
   logic                  r_avl_burstbegin;
   logic [3:0]            r_avl_size;
   logic                  r_avl_write_req;
   logic                  r_avl_read_req;
   logic [DATA_WIDTH-1:0] r_avl_wdata;

   logic                  w_cmd_pending;
   logic                  w_wr_request;
   logic                  w_rd_issued_all;
   logic                  w_wr_ready;
   logic                  w_rd_ready;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_ret;
   logic [c_ptr_w-1:0]    w_wr_base;
   logic [c_ptr_w-1:0]    w_rd_base;
   logic [c_ptr_w-1:0]    w_wr_ptr_inc;
   logic [c_ptr_w-1:0]    w_ret_inc;

   // A registered command not taken by the controller blocks any new acceptance.
   assign w_cmd_pending   = (r_avl_write_req | r_avl_read_req) & ~avl_ready;
   assign w_wr_request    = ~wr_en_n & ~r_full;
   assign w_rd_issued_all = (r_rd_iss_ptr == c_frame);
   assign w_ret           = avl_rdata_valid & (r_outstanding != '0);

   // A restart coinciding with a new burst/read starts the new frame at pixel 0.
   assign w_wr_base    = (wr_restart && r_state == S_IDLE) ? '0 : r_wr_ptr;
   assign w_rd_base    = rd_restart ? '0 : r_rd_iss_ptr;
   assign w_wr_ptr_inc = r_wr_ptr + c_ptr_one;
   assign w_ret_inc    = r_rd_ret_cnt + c_ptr_one;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wr_ready  = 1'b0;
      w_rd_ready  = 1'b0;
      w_wr_acc    = 1'b0;
      w_rd_acc    = 1'b0;
      if (reset) begin
         case (r_state)
            S_IDLE: begin
               w_wr_ready = ~r_full & ~w_cmd_pending;
               w_rd_ready = ~w_cmd_pending & ~w_rd_issued_all &
                            (r_outstanding < c_ost_max) & ~w_wr_request;
               w_wr_acc   = ~wr_en_n & w_wr_ready;
               w_rd_acc   = ~rd_en_n & w_rd_ready;
               if (w_wr_acc && (BURST_SIZE > 1)) begin
                  w_state_nxt = S_WR_BURST;
               end
            end
            S_WR_BURST: begin
               w_wr_ready = ~w_cmd_pending;
               w_wr_acc   = ~wr_en_n & w_wr_ready;
               if (w_wr_acc && r_beat_cnt == c_beat_last) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Write pointer, burst beat count and full flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr      <= '0;
         r_beat_cnt    <= '0;
         r_full        <= 1'b0;
         r_wr_rst_pend <= 1'b0;
      end else if (r_state == S_WR_BURST) begin
         if (wr_restart) begin
            r_wr_rst_pend <= 1'b1;
         end
         if (w_wr_acc) begin
            if (w_state_nxt == S_IDLE) begin
               // Deferred restart lands only once the open burst has finished.
               r_beat_cnt <= '0;
               if (wr_restart || r_wr_rst_pend) begin
                  r_wr_ptr      <= '0;
                  r_full        <= 1'b0;
                  r_wr_rst_pend <= 1'b0;
               end else begin
                  r_wr_ptr <= w_wr_ptr_inc;
                  r_full   <= (w_wr_ptr_inc == c_frame);
               end
            end else begin
               r_wr_ptr   <= w_wr_ptr_inc;
               r_beat_cnt <= r_beat_cnt + 4'd1;
            end
         end
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr   <= w_wr_base + c_ptr_one;
            r_full     <= ~wr_restart && (w_wr_base + c_ptr_one == c_frame);
            r_beat_cnt <= 4'd1;
         end else if (wr_restart) begin
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
         end
      end
   end

   // Read issue pointer, outstanding count, return count and done flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_iss_ptr    <= '0;
         r_outstanding   <= '0;
         r_rd_ret_cnt    <= '0;
         r_rd_done       <= 1'b0;
         r_rd_data_valid <= 1'b0;
         r_rd_data       <= '0;
      end else begin
         if (w_rd_acc) begin
            r_rd_iss_ptr <= w_rd_base + c_ptr_one;
         end else if (rd_restart) begin
            r_rd_iss_ptr <= '0;
         end

         case ({w_rd_acc, w_ret})
            2'b10:   r_outstanding <= r_outstanding + c_ost_one;
            2'b01:   r_outstanding <= r_outstanding - c_ost_one;
            default: r_outstanding <= r_outstanding;
         endcase

         // Words still in flight across a restart belong to the new frame.
         if (rd_restart) begin
            r_rd_ret_cnt <= w_ret ? c_ptr_one : '0;
            r_rd_done    <= 1'b0;
         end else if (w_ret && !r_rd_done) begin
            r_rd_ret_cnt <= w_ret_inc;
            r_rd_done    <= (w_ret_inc == c_frame);
         end

         r_rd_data_valid <= w_ret;
         r_rd_data       <= avl_rdata;
      end
   end

   // Registered Avalon command; held untouched while the controller stalls.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_avl_addr       <= c_base;
         r_avl_burstbegin <= 1'b0;
         r_avl_size       <= '0;
         r_avl_write_req  <= 1'b0;
         r_avl_read_req   <= 1'b0;
         r_avl_wdata      <= '0;
      end else if (w_wr_acc) begin
         r_avl_write_req  <= 1'b1;
         r_avl_read_req   <= 1'b0;
         r_avl_wdata      <= wr_data;
         r_avl_size       <= c_burst_sz;
         r_avl_burstbegin <= (r_state == S_IDLE);
         if (r_state == S_IDLE) begin
            r_avl_addr <= c_base + ADDR_WIDTH'(w_wr_base);
         end
      end else if (w_rd_acc) begin
         r_avl_write_req  <= 1'b0;
         r_avl_read_req   <= 1'b1;
         r_avl_burstbegin <= 1'b1;
         r_avl_size       <= 4'd1;
         r_avl_addr       <= c_base + ADDR_WIDTH'(w_rd_base);
      end else if (!w_cmd_pending) begin
         r_avl_write_req  <= 1'b0;
         r_avl_read_req   <= 1'b0;
         r_avl_burstbegin <= 1'b0;
      end
   end

`ifdef FB_DBG_CNT_EN
   logic [15:0] r_dbg_err_cnt;
   logic        w_dbg_err;

   assign w_dbg_err = (~wr_en_n & r_full) | (~rd_en_n & w_rd_issued_all) |
                      (avl_rdata_valid & (r_outstanding == '0));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_dbg_err_cnt <= '0;
      end else if (w_dbg_err && r_dbg_err_cnt != 16'hFFFF) begin
         r_dbg_err_cnt <= r_dbg_err_cnt + 16'd1;
      end
   end

   assign dbg_err_cnt = r_dbg_err_cnt;
`endif

   assign wr_ready       = w_wr_ready;
   assign rd_ready       = w_rd_ready;
   assign full           = r_full;
   assign rd_done        = r_rd_done;
   assign rd_data_valid  = r_rd_data_valid;
   assign rd_data        = r_rd_data;
   assign avl_addr       = r_avl_addr;
   assign avl_burstbegin = r_avl_burstbegin;
   assign avl_size       = r_avl_size;
   assign avl_write_req  = r_avl_write_req;
   assign avl_read_req   = r_avl_read_req;
   assign avl_wdata      = r_avl_wdata;

endmodule
`default_nettype wire
